// File: rtl/sync_reqack_dst_ctrl.sv
// sync_reqack_dst_ctrl
//
// DST-domain command controller for the REQ/ACK CDC channel. One command is
// accepted per handshake. It is dispatched to one of NumTgt local targets, and
// the controller waits for that target's completion or a timeout. It then
// returns a response word and closes the handshake with a single-cycle ACK.
//
// The response word and error flag are registered. They change only when a
// command completes, so the DST->SRC data path can sample them unregistered
// at any time after the ACK, up to the next completion.
//
// Ports
//   clk_dst_i    DST clock
//   rst_dst_ni   asynchronous active-low reset, DST domain
//   dst_req_i    REQ from the synchronizer DST side (held until dst_ack_o)
//   dst_ack_o    single-cycle ACK back to the synchronizer
//   dst_cmd_i    {target index, write payload}, valid while dst_req_i is high
//   dst_rsp_o    response word to the DST->SRC data path
//   dst_err_o    error flag for dst_rsp_o (invalid index or timeout)
//   tgt_req_o    one-hot target request, held for the whole BUSY state
//   tgt_wdata_o  write payload latched at command acceptance
//   tgt_done_i   per-target completion pulse
//   tgt_rdata_i  per-target read data; slice i is valid with tgt_done_i[i]

module sync_reqack_dst_ctrl #(
    parameter int unsigned     Width         = 32,
    parameter int unsigned     NumTgt        = 4,
    parameter int unsigned     TgtIdxW       = $clog2(NumTgt),
    parameter int unsigned     TimeoutCycles = 255,
    parameter logic [Width-1:0] ErrRsp       = 32'hDEAD_BEEF
) (
    input  logic                      clk_dst_i,
    input  logic                      rst_dst_ni,

    input  logic                      dst_req_i,
    output logic                      dst_ack_o,
    input  logic [TgtIdxW+Width-1:0]  dst_cmd_i,
    output logic [Width-1:0]          dst_rsp_o,
    output logic                      dst_err_o,

    output logic [NumTgt-1:0]         tgt_req_o,
    output logic [Width-1:0]          tgt_wdata_o,
    input  logic [NumTgt-1:0]         tgt_done_i,
    input  logic [NumTgt*Width-1:0]   tgt_rdata_i
);

    // A zero TimeoutCycles disables the timeout; keep a 1-bit counter so the
    // declarations stay legal, and never advance it.
    localparam bit          TimeoutEn = (TimeoutCycles != 0);
    localparam int unsigned CntW      = TimeoutEn ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntW-1:0] CntLast = TimeoutEn ? CntW'(TimeoutCycles - 1) : '0;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StAck
    } state_e;

    state_e             state_q, state_d;
    logic [TgtIdxW-1:0] idx_q, idx_d;
    logic [Width-1:0]   wdata_q, wdata_d;
    logic [Width-1:0]   rsp_q, rsp_d;
    logic               err_q, err_d;
    logic [CntW-1:0]    cnt_q, cnt_d;

    // Command field split.
    logic [TgtIdxW-1:0] cmd_idx;
    logic [Width-1:0]   cmd_data;
    logic               cmd_idx_valid;

    assign cmd_idx       = dst_cmd_i[TgtIdxW+Width-1 -: TgtIdxW];
    assign cmd_data      = dst_cmd_i[Width-1:0];
    // Only reachable as invalid when NumTgt is not a power of two.
    assign cmd_idx_valid = (32'(cmd_idx) < NumTgt);

    // Selected-target done and read data. idx_q is always a valid index while
    // BUSY, since invalid indices go straight to ACK.
    logic             sel_done;
    logic [Width-1:0] sel_rdata;

    always_comb begin
        sel_done  = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < NumTgt; i++) begin
            if (32'(idx_q) == i) begin
                sel_done  = tgt_done_i[i];
                sel_rdata = tgt_rdata_i[i*Width +: Width];
            end
        end
    end

    logic timeout_hit;
    assign timeout_hit = TimeoutEn && (cnt_q == CntLast);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rsp_d   = rsp_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            StIdle: begin
                if (dst_req_i) begin
                    idx_d   = cmd_idx;
                    wdata_d = cmd_data;
                    if (!cmd_idx_valid) begin
                        rsp_d   = ErrRsp;
                        err_d   = 1'b1;
                        state_d = StAck;
                    end else begin
                        cnt_d   = '0;
                        state_d = StBusy;
                    end
                end
            end

            StBusy: begin
                // Done has priority over a timeout expiring in the same cycle.
                if (sel_done) begin
                    rsp_d   = sel_rdata;
                    err_d   = 1'b0;
                    state_d = StAck;
                end else if (timeout_hit) begin
                    rsp_d   = ErrRsp;
                    err_d   = 1'b1;
                    state_d = StAck;
                end else if (TimeoutEn) begin
                    // Exits at CntLast, so the counter never wraps.
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StAck: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_dst_i or negedge rst_dst_ni) begin
        if (!rst_dst_ni) begin
            state_q <= StIdle;
            idx_q   <= '0;
            wdata_q <= '0;
            rsp_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rsp_q   <= rsp_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs.
    always_comb begin
        tgt_req_o = '0;
        for (int unsigned i = 0; i < NumTgt; i++) begin
            tgt_req_o[i] = (state_q == StBusy) && (32'(idx_q) == i);
        end
    end

    assign dst_ack_o   = (state_q == StAck);
    assign dst_rsp_o   = rsp_q;
    assign dst_err_o   = err_q;
    assign tgt_wdata_o = wdata_q;

endmodule

// File: doc/sync_reqack_dst_ctrl.md
# sync_reqack_dst_ctrl

DST-domain command controller for the REQ/ACK CDC channel. It accepts one command per handshake from the synchronizer's DST side (dst_req with target index and write payload) and dispatches it to one of NumTgt local targets. It waits for the target's completion or a timeout, then returns the response word on the DST→SRC data path and closes the handshake with a single-cycle ACK. The response is held stable until the next accepted command, which meets the unregistered DST→SRC data hold requirement without an extra register stage in the synchronizer.

## Interface
- Width, 32, payload and response data width.
- NumTgt, 4, number of targets (2..16).
- TgtIdxW, $clog2(NumTgt), target index field width (derived).
- TimeoutCycles, 255, BUSY cycles before abort; 0 disables the timeout.
- ErrRsp, 32'hDEAD_BEEF, response word returned on error (Width bits).
- clk_dst_i  in  1  DST clock.
- rst_dst_ni  in  1  asynchronous, active-low reset, DST domain.
- dst_req_i  in  1  REQ from the synchronizer DST side; high until dst_ack_o.
- dst_ack_o  out  1  single-cycle ACK to the synchronizer.
- dst_cmd_i  in  TgtIdxW+Width  {target index, write payload}; valid while dst_req_i is high.
- dst_rsp_o  out  Width  response word to the DST→SRC data path.
- dst_err_o  out  1  error flag accompanying dst_rsp_o (invalid index or timeout).
- tgt_req_o  out  NumTgt  one-hot request, held for the whole BUSY state.
- tgt_wdata_o  out  Width  latched write payload.
- tgt_done_i  in  NumTgt  per-target completion pulse.
- tgt_rdata_i  in  NumTgt*Width  per-target read data; slice i is valid with tgt_done_i[i].

## Operation
- FSM states: IDLE, BUSY, ACK. All registers reset asynchronously to IDLE / zero.
- IDLE:
  - On dst_req_i, latch the index into idx_q and the payload into tgt_wdata_o.
  - If the index is ≥ NumTgt: set dst_rsp_o=ErrRsp, dst_err_o=1, and go to ACK.
  - Otherwise clear the timeout counter and go to BUSY.
- BUSY:
  - tgt_req_o = onehot(idx_q).
  - If tgt_done_i[idx_q]=1: capture tgt_rdata_i slice idx_q into dst_rsp_o, set dst_err_o=0, and go to ACK.
  - Else if TimeoutCycles≠0 and cnt==TimeoutCycles-1: set dst_rsp_o=ErrRsp, dst_err_o=1, and go to ACK.
  - Else cnt+1.
  - Done pulses on non-selected targets are ignored.
- ACK: dst_ack_o=1 for exactly one cycle, tgt_req_o=0, then go to IDLE.
- dst_rsp_o and dst_err_o change only on the IDLE/BUSY→ACK transition. They stay stable through ACK and afterwards until the next command completes.
- tgt_wdata_o changes only on command acceptance.
- The counter width is $clog2(TimeoutCycles+1) and never wraps: it stops at the terminal value.

## Timing
- Reset values: dst_ack_o=0, dst_rsp_o=0, dst_err_o=0, tgt_req_o=0, tgt_wdata_o=0, state=IDLE.
- Command accepted at cycle 0 (IDLE with dst_req_i=1):
  - tgt_req_o is asserted from cycle 1.
  - With tgt_done_i in cycle k≥1, dst_ack_o pulses in cycle k+1 and dst_rsp_o is valid from cycle k+1.
- Invalid index: dst_ack_o pulses in cycle 1; tgt_req_o is never asserted.
- Timeout: with no done, dst_ack_o pulses in cycle TimeoutCycles+1.
- Done and timeout in the same cycle: done wins, dst_err_o=0.
- A done pulse in cycle 1 gives minimum valid-target latency: ACK in cycle 2.
- dst_req_i is don't-care in BUSY and ACK. In the cycle after ACK, dst_req_i is low by protocol; a high there is treated as a new command.
- Reset mid-operation returns to IDLE immediately with outputs cleared and no ACK issued. The SRC side must be reset together with the DST side.
- Throughput: one command per k+2 cycles minimum (IDLE, BUSY…, ACK).

## Test plan
- Reset with all inputs X→0 → all outputs 0, state IDLE; dst_ack_o stays 0 for 10 cycles.
- Command {idx=2, data=32'h1234_5678}; tgt_done_i[2] in cycle 3 with rdata slice 2 = 32'hCAFE_0002:
  - tgt_req_o=4'b0100 in cycles 1-3, tgt_wdata_o=32'h1234_5678.
  - ACK in cycle 4, dst_rsp_o=32'hCAFE_0002, dst_err_o=0, held until the next command.
- NumTgt=3, command idx=3 → ACK in cycle 1, dst_rsp_o=32'hDEAD_BEEF, dst_err_o=1, tgt_req_o never set.
- TimeoutCycles=8, idx=1, tgt_done_i[1] never asserted:
  - ACK in cycle 9, dst_err_o=1, dst_rsp_o=ErrRsp.
  - tgt_done_i[0] pulses during BUSY are ignored.
- Done on the selected target in the same cycle as timeout expiry → dst_err_o=0 and target rdata is returned.
- Reset asserted in cycle 2 of BUSY → tgt_req_o=0 immediately, no dst_ack_o, and a fresh command afterwards completes normally.
